// File: rtl/explosion_pkg.sv
// explosion_pkg: shared sprite constants and the per-slot record for the explosion scheduler
package explosion_pkg;
    localparam int         SPR_W           = 30;
    localparam int         SPR_DEPTH       = SPR_W * SPR_W;
    localparam logic [3:0] TRANSPARENT_IDX = 4'h0;
    typedef struct packed {
        logic       active;
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] life;
    } expl_slot_t;
endpackage

// File: rtl/expl_slot_hit.sv
// expl_slot_hit: sprite-box hit test and sprite RAM offset for one explosion slot
module expl_slot_hit
    import explosion_pkg::*;
(
    input  logic        active,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    output logic        hit,
    output logic [18:0] addr
);
    logic [10:0] dx, dy;
    // 11-bit unsigned distances; the >= guards keep sprites near 1023 from wrapping to 0
    always_comb begin
        dx   = {1'b0, draw_x} - {1'b0, x};
        dy   = {1'b0, draw_y} - {1'b0, y};
        hit  = active && draw_x >= x && draw_y >= y && dx < 11'(SPR_W) && dy < 11'(SPR_W);
        addr = 19'(dy) * 19'(SPR_W) + 19'(dx);
    end
endmodule

// File: rtl/explosion_sched.sv
// explosion_sched: allocates and ages explosion slots and shares the sprite RAM read port among them
module explosion_sched
    import explosion_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int LIFETIME  = 16
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_tick,
    input  logic        trig_valid,
    input  logic [9:0]  trig_x,
    input  logic [9:0]  trig_y,
    output logic        trig_ready,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [18:0] ram_read_address,
    input  logic [3:0]  ram_data,
    output logic        expl_on,
    output logic [3:0]  expl_color,
    output logic [3:0]  active_count
);
    expl_slot_t           slots   [NUM_SLOTS];
    expl_slot_t           slots_n [NUM_SLOTS];
    logic [18:0]          addrs   [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] hits;
    logic [18:0]          win_addr;
    logic [3:0]           count_n;
    logic                 taken, hit_d1, hit_d2;

    // a fresh spawn takes priority over ageing, so it keeps its full LIFETIME
    always_comb begin
        trig_ready = 1'b0;
        taken      = 1'b0;
        count_n    = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            trig_ready |= ~slots[i].active;
            slots_n[i] = slots[i];
            if (trig_valid && !taken && !slots[i].active) begin
                slots_n[i] = '{1'b1, trig_x, trig_y, 8'(LIFETIME)};
                taken      = 1'b1;
            end else if (frame_tick && slots[i].active) begin
                slots_n[i].active = slots[i].life != 8'd1;
                slots_n[i].life   = slots[i].life - 8'd1;
            end
            count_n += 4'(slots_n[i].active);
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_hit
        expl_slot_hit u_hit (
            .active (slots[g].active),
            .x      (slots[g].x),
            .y      (slots[g].y),
            .draw_x (DrawX),
            .draw_y (DrawY),
            .hit    (hits[g]),
            .addr   (addrs[g])
        );
    end

    // scanning downward lets the lowest hitting index win
    always_comb begin
        win_addr = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            win_addr = hits[i] ? addrs[i] : win_addr;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
            active_count     <= '0;
            ram_read_address <= '0;
            hit_d1           <= 1'b0;
            hit_d2           <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= slots_n[i];
            active_count     <= count_n;
            ram_read_address <= win_addr;
            hit_d1           <= |hits;
            hit_d2           <= hit_d1;
        end
    end

    // ram_data arrives one cycle after the address, already aligned with hit_d2
    always_comb begin
        expl_color = hit_d2 ? ram_data : 4'h0;
        expl_on    = hit_d2 && ram_data != TRANSPARENT_IDX;
    end
endmodule

// File: tb/tb_explosion_sched.sv
// tb_explosion_sched: directed and random stimulus against a behavioural slot/pixel model
module tb_explosion_sched;
    localparam int NS = 4;
    localparam int LT = 3;
    localparam int W  = 30;

    logic        Clk = 1'b0;
    logic        Reset_n, frame_tick, trig_valid, trig_ready, expl_on;
    logic [9:0]  trig_x, trig_y, DrawX, DrawY;
    logic [18:0] ram_read_address;
    logic [3:0]  ram_data, expl_color, active_count;
    logic [3:0]  mem [1024];

    int vectors = 0, miscompares = 0;
    int m_act [NS], m_x [NS], m_y [NS], m_life [NS];
    int m_addr = 0, m_hit1 = 0, m_hit2 = 0, m_rd = 0;

    explosion_sched #(.NUM_SLOTS(NS), .LIFETIME(LT)) dut (
        .Clk              (Clk),
        .Reset_n          (Reset_n),
        .frame_tick       (frame_tick),
        .trig_valid       (trig_valid),
        .trig_x           (trig_x),
        .trig_y           (trig_y),
        .trig_ready       (trig_ready),
        .DrawX            (DrawX),
        .DrawY            (DrawY),
        .ram_read_address (ram_read_address),
        .ram_data         (ram_data),
        .expl_on          (expl_on),
        .expl_color       (expl_color),
        .active_count     (active_count)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) ram_data <= mem[ram_read_address[9:0]];

    task automatic check(string tag, int got, int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void pixel(output int hit, output int addr);
        hit  = 0;
        addr = 0;
        for (int i = NS - 1; i >= 0; i--)
            if (m_act[i] != 0 && int'(DrawX) >= m_x[i] && int'(DrawX) < m_x[i] + W &&
                int'(DrawY) >= m_y[i] && int'(DrawY) < m_y[i] + W) begin
                hit  = 1;
                addr = (int'(DrawY) - m_y[i]) * W + int'(DrawX) - m_x[i];
            end
    endfunction

    task automatic step();
        int h, a, free_i, ready, cnt;
        pixel(h, a);
        @(posedge Clk);
        #1;
        m_rd = int'(mem[m_addr]);
        if (!Reset_n) begin
            for (int i = 0; i < NS; i++) begin
                m_act[i] = 0; m_life[i] = 0;
            end
            m_addr = 0; m_hit1 = 0; m_hit2 = 0;
        end else begin
            m_hit2 = m_hit1;
            m_hit1 = h;
            m_addr = h ? a : 0;
            free_i = -1;
            for (int i = NS - 1; i >= 0; i--) if (m_act[i] == 0) free_i = i;
            for (int i = 0; i < NS; i++) begin
                if (trig_valid && i == free_i) begin
                    m_act[i] = 1; m_x[i] = int'(trig_x); m_y[i] = int'(trig_y); m_life[i] = LT;
                end else if (frame_tick && m_act[i] != 0) begin
                    m_life[i]--;
                    if (m_life[i] == 0) m_act[i] = 0;
                end
            end
        end
        ready = 0;
        cnt   = 0;
        for (int i = 0; i < NS; i++) begin
            if (m_act[i] == 0) ready = 1;
            cnt += m_act[i];
        end
        check("trig_ready", int'(trig_ready), ready);
        check("active_count", int'(active_count), cnt);
        check("ram_read_address", int'(ram_read_address), m_addr);
        check("expl_on", int'(expl_on), (m_hit2 != 0 && m_rd != 0) ? 1 : 0);
        check("expl_color", int'(expl_color), m_hit2 != 0 ? m_rd : 0);
    endtask

    task automatic spawn(int x, int y);
        trig_valid = 1'b1;
        trig_x     = 10'(x);
        trig_y     = 10'(y);
        step();
        trig_valid = 1'b0;
    endtask

    task automatic draw(int x, int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
    endtask

    initial begin
        int k, v;
        for (int i = 0; i < 1024; i++) mem[i] = ($urandom % 4 == 0) ? 4'h0 : 4'($urandom);
        mem[64] = 4'h7;
        mem[65] = 4'h0;
        for (int i = 0; i < NS; i++) begin
            m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_life[i] = 0;
        end
        Reset_n = 1'b0; frame_tick = 1'b0; trig_valid = 1'b0;
        trig_x = '0; trig_y = '0;
        draw(0, 0);
        step();
        step();
        check("reset_ready", int'(trig_ready), 1);
        check("reset_addr", int'(ram_read_address), 0);
        Reset_n = 1'b1;

        spawn(100, 50);
        draw(104, 52);
        step();
        check("addr_64", int'(ram_read_address), 64);
        step();
        check("on_color7", int'(expl_on), 1);
        check("color_7", int'(expl_color), 7);
        draw(105, 52);
        step();
        step();
        check("transparent_off", int'(expl_on), 0);
        draw(130, 52);
        step();
        step();
        check("dx30_off", int'(expl_on), 0);

        spawn(1010, 0);
        draw(1023, 0);
        step();
        check("clip_addr_13", int'(ram_read_address), 13);
        draw(5, 0);
        step();
        check("no_wrap", int'(ram_read_address), 0);

        spawn(110, 55);
        spawn(500, 500);
        check("full_ready", int'(trig_ready), 0);
        spawn(7, 7);
        check("full_ignored", int'(active_count), 4);
        draw(115, 60);
        step();
        check("arb_slot0", int'(ram_read_address), 315);

        frame_tick = 1'b1;
        step();
        step();
        check("alive_tick2", int'(active_count), 4);
        trig_valid = 1'b1;
        step();
        trig_valid = 1'b0;
        frame_tick = 1'b0;
        check("expired", int'(active_count), 0);
        check("ready_after_free", int'(trig_ready), 1);

        trig_valid = 1'b1; frame_tick = 1'b1;
        trig_x = 10'd200; trig_y = 10'd200;
        step();
        trig_valid = 1'b0;
        step();
        step();
        check("spawn_tick_kept", int'(active_count), 1);
        step();
        frame_tick = 1'b0;
        check("spawn_tick_gone", int'(active_count), 0);

        spawn(300, 300);
        spawn(310, 310);
        spawn(320, 320);
        draw(305, 305);
        step();
        step();
        Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
        check("midrun_count", int'(active_count), 0);
        check("midrun_on", int'(expl_on), 0);
        check("midrun_ready", int'(trig_ready), 1);

        for (int n = 0; n < 3000; n++) begin
            Reset_n    = ($urandom % 300) != 0;
            trig_valid = ($urandom % 4) == 0;
            trig_x     = ($urandom % 8 == 0) ? 10'(990 + $urandom % 34) : 10'($urandom);
            trig_y     = ($urandom % 8 == 0) ? 10'(990 + $urandom % 34) : 10'($urandom);
            frame_tick = ($urandom % 10) == 0;
            k = int'($urandom % NS);
            if (m_act[k] != 0 && ($urandom % 8) != 0) begin
                v = m_x[k] + int'($urandom_range(0, 36)) - 3;
                DrawX = 10'((v < 0) ? 0 : (v > 1023) ? 1023 : v);
                v = m_y[k] + int'($urandom_range(0, 36)) - 3;
                DrawY = 10'((v < 0) ? 0 : (v > 1023) ? 1023 : v);
            end else begin
                DrawX = 10'($urandom);
                DrawY = 10'($urandom);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
